fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 40: FPU result-settle wait in cycles; legal range 32..255.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clock  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester operation request.
REQ-006 req_ready  output  2  per-requester accept strobe.
REQ-007 req_a0, req_b0  input  32  requester 0 operands.
REQ-008 req_a1, req_b1  input  32  requester 1 operands.
REQ-009 rsp_valid  output  1  response held until rsp_ready.
REQ-010 rsp_ready  input  1  response consumer handshake.
REQ-011 rsp_id  output  1  requester index of the response.
REQ-012 rsp_data, rsp_status  output  32, 4  captured FPU data_out and status_out.
REQ-013 fpu_op_a, fpu_op_b  output  32  to FPU op_A_in/op_B_in.
REQ-014 fpu_reset  output  1  to FPU active-low reset; 0 restarts the FPU sequence.
REQ-015 fpu_data, fpu_status  input  32, 4  from FPU data_out/status_out.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with transitions IDLE->ISSUE on accept, ISSUE->WAIT always, WAIT->RESP when the counter reaches 0, and RESP->IDLE on rsp_valid and rsp_ready.
REQ-018 In IDLE with at least one req_valid set, the arbiter SHALL grant exactly one requester, pulse that requester's req_ready for one cycle (combinational: IDLE and granted and valid), and latch its operands and index.
REQ-019 req_ready SHALL be 0 in every state other than IDLE, so no request is accepted while busy.
REQ-020 When only one requester is valid, that requester SHALL be granted regardless of the pointer.
REQ-021 In ISSUE, fpu_reset SHALL be 0 for exactly one cycle; in every other state fpu_reset SHALL be 1.
REQ-022 fpu_op_a and fpu_op_b SHALL drive the latched operands from ISSUE through RESP, and SHALL keep their previous values in IDLE.
REQ-023 On entry to WAIT, the 8-bit counter SHALL load WAIT_CYCLES-1 and decrement once per cycle.
REQ-024 At count 0, the block SHALL capture fpu_data and fpu_status into rsp_data and rsp_status and enter RESP.
REQ-025 Latency SHALL be fixed: rsp_valid rises exactly WAIT_CYCLES+2 cycles after the accepting edge.
REQ-026 In RESP, rsp_valid, rsp_id, rsp_data and rsp_status SHALL stay stable until rsp_ready is sampled high.
REQ-027 The block SHALL take the IDLE-to-accept path no earlier than the cycle after RESP exits; there is no back-to-back bypass.
REQ-028 rsp_ready SHALL be ignored when rsp_valid is 0.
REQ-029 Data SHALL pass through unmodified: the block performs no arithmetic on operands or results.

Reset
REQ-030 On reset the block SHALL go to IDLE, and rsp_valid, rsp_id, rsp_data, rsp_status, fpu_op_a, fpu_op_b, counter and rr pointer SHALL all become 0.
REQ-031 While reset is asserted, fpu_reset SHALL be 0 and busy SHALL be 0.
REQ-032 Reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL abort it, with no response and no req_ready in that cycle.

Configuration
REQ-033 With FPU_ARB_RR_EN defined, grants SHALL be round-robin: a 1-bit pointer names the preferred requester and toggles to the other index after each accept.
REQ-034 Without FPU_ARB_RR_EN, requester 0 SHALL have fixed priority, with no pointer register.

Structure
REQ-035 Package fpu_arb_pkg SHALL hold the state enum typedef, the FPU field constants (sign bit 31, exponent 30:25, mantissa 24:0, BIAS 31) and the status codes (EXACT 0001, INEXACT 1111, OVERFLOW 0011, UNDERFLOW 0111).
REQ-036 Sub-module fpu_arb_pick SHALL implement the combinational 2-way grant (valid[1:0], pointer -> grant index, any).
REQ-037 The FSM, counter and registers SHALL live in fpu_arbiter, which instantiates the FPU externally and does not contain it.

Verification
REQ-038 Single request: req_valid=01, a0=0x3E000000, b0=0x3E000000 -> req_ready=01 for 1 cycle; rsp_valid at accept+42; rsp_data=0x40000000, rsp_status=0001, rsp_id=0.
REQ-039 Contention (RR_EN): both valid continuously, rsp_ready=1 -> grants 0,1,0,1; rsp_id alternates; no ready while busy.
REQ-040 Fixed priority (no RR_EN): both valid continuously -> four responses all rsp_id=0; requester 1 is never granted.
REQ-041 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_data stable; no new accept until the cycle after rsp_ready=1.
REQ-042 Reset in WAIT at count 20 -> next cycle IDLE, busy=0, rsp_valid=0, fpu_reset=0 during reset; the following request completes normally.
REQ-043 Overflow passthrough: a=b=0x7E000000 -> rsp_status=0011, rsp_data=0x7E000000; operands stable on fpu_op_a/fpu_op_b throughout.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the two-requester FPU arbiter: FSM encoding, FPU word
// layout and FPU status codes.
package fpu_arb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_RESP  = S_RESP
    } fpu_arb_state_e;

    // FPU word layout: 1 sign, 6 exponent (bias 31), 25 mantissa
    localparam int FPU_SIGN_BIT = 31;
    localparam int FPU_EXP_MSB  = 30;
    localparam int FPU_EXP_LSB  = 25;
    localparam int FPU_MAN_MSB  = 24;
    localparam int FPU_MAN_LSB  = 0;
    localparam int FPU_BIAS     = 31;

    localparam logic [3:0] FPU_ST_EXACT     = 4'b0001;
    localparam logic [3:0] FPU_ST_INEXACT   = 4'b1111;
    localparam logic [3:0] FPU_ST_OVERFLOW  = 4'b0011;
    localparam logic [3:0] FPU_ST_UNDERFLOW = 4'b0111;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fpu_arb_pick.sv
// Combinational 2-way grant: a lone requester always wins; on contention the
// pointer names the winner.
module fpu_arb_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic       idx,
    output logic       any
);

    assign any = |valid;
    assign idx = (&valid) ? ptr : valid[1];

endmodule

// File: rtl/fpu_arbiter.sv
// Arbitrates two requesters onto one external FPU with a fixed settle wait.
// Define FPU_ARB_RR_EN for round-robin grants; default is requester-0 priority.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_status,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    output logic        fpu_reset,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,
    output logic        busy
);

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] count;
    logic       id_q;
    logic       rsp_valid_q;
    logic       ptr;
    logic       gnt_idx;
    logic       gnt_any;
    logic       accept;

`ifdef FPU_ARB_RR_EN
    logic rr_ptr;

    // The winner hands preference to the other requester
    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (accept)
            rr_ptr <= ~gnt_idx;
    end

    assign ptr = rr_ptr;
`else
    assign ptr = 1'b0;
`endif

    fpu_arb_pick u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign accept    = (state == S_IDLE) && gnt_any && !reset;
    assign req_ready = accept ? (grant_onehot(gnt_idx) & req_valid) : 2'b00;
    assign busy      = (state != S_IDLE) && !reset;
    assign fpu_reset = !reset && (state != S_ISSUE);
    // Reset kills a pending response in the same cycle it is raised
    assign rsp_valid = rsp_valid_q && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= 8'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_status  <= 4'd0;
            fpu_op_a    <= 32'd0;
            fpu_op_b    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_ISSUE;
                        id_q     <= gnt_idx;
                        fpu_op_a <= gnt_idx ? req_a1 : req_a0;
                        fpu_op_b <= gnt_idx ? req_b1 : req_b0;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    count <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (count == 8'd0) begin
                        state      <= S_RESP;
                        rsp_id     <= id_q;
                        rsp_data   <= fpu_data;
                        rsp_status <= fpu_status;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                S_RESP: begin
                    // Captured data settles one cycle before rsp_valid rises
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter with a behavioural FPU stand-in and a
// request-level arbitration model. Honours FPU_ARB_RR_EN like the design.
module tb_fpu_arbiter;
    import fpu_arb_pkg::*;

    localparam int WAIT_CYCLES = 40;
    localparam int SETTLE      = 30;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic [31:0] fpu_op_a, fpu_op_b;
    logic        fpu_reset;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic        busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic mptr  = 1'b0;

    fpu_arbiter #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .fpu_op_a   (fpu_op_a),
        .fpu_op_b   (fpu_op_b),
        .fpu_reset  (fpu_reset),
        .fpu_data   (fpu_data),
        .fpu_status (fpu_status),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in FPU: equal positive powers of two double, else a scrambled result
    function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
        logic [6:0] e;
        if (a == b && !a[FPU_SIGN_BIT] && a[FPU_MAN_MSB:FPU_MAN_LSB] == 25'd0) begin
            e = {1'b0, a[FPU_EXP_MSB:FPU_EXP_LSB]} + 7'd1;
            if (e >= 7'd63)
                return {FPU_ST_OVERFLOW, 1'b0, 6'h3F, 25'd0};
            return {FPU_ST_EXACT, 1'b0, e[5:0], 25'd0};
        end
        return {FPU_ST_INEXACT, a ^ {b[15:0], b[31:16]}};
    endfunction

    // Output is junk until SETTLE cycles after the restart pulse
    int settle_cnt = 0;
    always @(posedge clock) begin
        if (!fpu_reset) begin
            settle_cnt <= 0;
            fpu_data   <= 32'hDEAD_BEEF;
            fpu_status <= 4'hA;
        end else if (settle_cnt < SETTLE) begin
            settle_cnt <= settle_cnt + 1;
            if (settle_cnt == SETTLE - 1)
                {fpu_status, fpu_data} <= fpu_model(fpu_op_a, fpu_op_b);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Who should win: a lone requester, else the preferred one
    function automatic logic model_grant(input logic [1:0] v);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
`ifdef FPU_ARB_RR_EN
        return mptr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic note_accept(input logic gi);
`ifdef FPU_ARB_RR_EN
        mptr = ~gi;
`else
        mptr = 1'b0 & gi;
`endif
    endtask

    task automatic run_txn(input string tag, input logic [1:0] v,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input int hold,
                           output logic id_out, output logic [31:0] d_out,
                           output logic [3:0] s_out);
        logic        gi;
        logic [31:0] ea, eb;
        logic [35:0] exp;
        int          n, bad, bp_bad;
        req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        rsp_ready = 1'b1;
        #1;
        gi  = model_grant(v);
        ea  = gi ? a1 : a0;
        eb  = gi ? b1 : b0;
        exp = fpu_model(ea, eb);
        check({tag, " req_ready"}, 32'(req_ready), 32'(gi ? 2'b10 : 2'b01));
        tick();
        note_accept(gi);
        check({tag, " issue fpu_reset"}, 32'(fpu_reset), 32'd0);
        check({tag, " issue op_a"}, fpu_op_a, ea);
        n = 0; bad = 0;
        while (!rsp_valid && n < 300) begin
            tick();
            n++;
            if (req_ready !== 2'b00 || fpu_op_a !== ea || fpu_op_b !== eb ||
                fpu_reset !== 1'b1 || busy !== 1'b1)
                bad++;
        end
        check({tag, " latency"}, 32'(n), 32'(WAIT_CYCLES + 2));
        check({tag, " busy-window"}, 32'(bad), 32'd0);
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(gi));
        check({tag, " rsp_data"}, rsp_data, exp[31:0]);
        check({tag, " rsp_status"}, 32'(rsp_status), 32'(exp[35:32]));
        id_out = rsp_id; d_out = rsp_data; s_out = rsp_status;
        if (hold > 0) begin
            rsp_ready = 1'b0;
            bp_bad = 0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (rsp_valid !== 1'b1 || rsp_data !== exp[31:0] || rsp_status !== exp[35:32] ||
                    rsp_id !== gi || req_ready !== 2'b00 || busy !== 1'b1)
                    bp_bad++;
            end
            check({tag, " backpressure hold"}, 32'(bp_bad), 32'd0);
            rsp_ready = 1'b1;
        end
        tick();
        check({tag, " exit rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " exit busy"}, 32'(busy), 32'd0);
        check({tag, " idle op_a hold"}, fpu_op_a, ea);
    endtask

    initial begin
        logic        id;
        logic        prev_id;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] ra;

        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (3) tick();
        check("reset fpu_reset", 32'(fpu_reset), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        check("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("post-reset rsp_data", rsp_data, 32'd0);
        check("post-reset rsp_status", 32'(rsp_status), 32'd0);
        check("post-reset op_a", fpu_op_a, 32'd0);
        check("post-reset fpu_reset", 32'(fpu_reset), 32'd1);
        check("post-reset busy", 32'(busy), 32'd0);

        run_txn("single", 2'b01, 32'h3E00_0000, 32'h3E00_0000, $urandom, $urandom, 0, id, d, s);
        check("single literal data", d, 32'h4000_0000);
        check("single literal status", 32'(s), 32'(4'b0001));
        check("single literal id", 32'(id), 32'd0);

        run_txn("overflow", 2'b10, $urandom, $urandom, 32'h7E00_0000, 32'h7E00_0000, 0, id, d, s);
        check("overflow literal data", d, 32'h7E00_0000);
        check("overflow literal status", 32'(s), 32'(4'b0011));
        check("overflow literal id", 32'(id), 32'd1);

        run_txn("bp", 2'b01, $urandom, $urandom, $urandom, $urandom, 10, id, d, s);

        for (int k = 0; k < 4; k++) begin
            run_txn("contend", 2'b11, $urandom, $urandom, $urandom, $urandom, 0, id, d, s);
`ifdef FPU_ARB_RR_EN
            if (k > 0) check("contend alternation", 32'(id), 32'(~prev_id));
`else
            check("contend fixed prio id", 32'(id), 32'd0);
`endif
            prev_id = id;
        end

        // Abort during WAIT with the counter at 20
        ra = $urandom;
        req_valid = 2'b01; req_a0 = ra; req_b0 = ra;
        tick();
        note_accept(1'b0);
        req_valid = 2'b00;
        repeat (20) tick();
        req_valid = 2'b11;
        reset = 1'b1;
        #1;
        check("abort fpu_reset", 32'(fpu_reset), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 2'b00;
        reset = 1'b0;
        mptr = 1'b0;
        #1;
        check("after abort busy", 32'(busy), 32'd0);
        check("after abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("after abort op_a", fpu_op_a, 32'd0);
        run_txn("post-abort", 2'b01, 32'h3E00_0000, 32'h3E00_0000, $urandom, $urandom, 0, id, d, s);

        for (int k = 0; k < 8; k++) begin
            run_txn("random", 2'($urandom_range(1, 3)), $urandom, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), id, d, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
